// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for vector, data and fetch requesters
// Fixed priority V > D > F with a fetch anti-starvation override and one-cycle read return.
module mem_port_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          v_req,
   input  logic [AW-1:0] v_addr,
   output logic          v_gnt,
   output logic          v_rvalid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_lock,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {OWN_NONE, OWN_V, OWN_D, OWN_F} owner_t;

   owner_t        rd_owner;
   owner_t        rd_owner_nxt;
   logic [3:0]    starve_cnt;
   logic [3:0]    starve_nxt;
   logic [DW-1:0] rdata_q;
   logic          f_boost;

   // Grants are held low while reset is asserted so nothing reaches the memory.
   always_comb begin : grant
      v_gnt   = 1'b0;
      d_gnt   = 1'b0;
      f_gnt   = 1'b0;
      f_boost = (starve_cnt == 4'(STARVE_MAX)) && !d_lock;
      if (rstn) begin
         if (v_req)
            v_gnt = 1'b1;
         else if (f_req && f_boost)
            f_gnt = 1'b1;
         else if (d_req)
            d_gnt = 1'b1;
         else if (f_req)
            f_gnt = 1'b1;
      end
   end

   always_comb begin : mem_mux
      mem_en    = v_gnt | d_gnt | f_gnt;
      mem_we    = d_gnt & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (v_gnt)
         mem_addr = v_addr;
      else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (f_gnt)
         mem_addr = f_addr;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_owner   <= OWN_NONE;
         starve_cnt <= 4'd0;
         rdata_q    <= '0;
      end else begin
         rd_owner   <= rd_owner_nxt;
         starve_cnt <= starve_nxt;
         rdata_q    <= rdata;
      end
   end

   always_comb begin : next_state
      rd_owner_nxt = OWN_NONE;
      if (v_gnt)
         rd_owner_nxt = OWN_V;
      else if (d_gnt && !d_we)
         rd_owner_nxt = OWN_D;
      else if (f_gnt)
         rd_owner_nxt = OWN_F;

      starve_nxt = 4'd0;
      if (f_req && !f_gnt)
         starve_nxt = (starve_cnt == 4'(STARVE_MAX)) ? starve_cnt : starve_cnt + 4'd1;
   end

   // rdata follows the memory only while a read returns, otherwise it holds.
   always_comb begin : outputs
      v_rvalid = (rd_owner == OWN_V);
      d_rvalid = (rd_owner == OWN_D);
      f_rvalid = (rd_owner == OWN_F);
      rdata    = (rd_owner != OWN_NONE) ? mem_rdata : rdata_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
// A registered-read memory is attached; expectations come from a priority/queue reference model.
module tb_mem_port_arbiter;

   localparam int SM = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       v_req = 1'b0;
   logic [7:0] v_addr = 8'h00;
   logic       v_gnt, v_rvalid;
   logic       d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
   logic [7:0] d_addr = 8'h00, d_wdata = 8'h00;
   logic       d_gnt, d_rvalid;
   logic       f_req = 1'b0;
   logic [7:0] f_addr = 8'h00;
   logic       f_gnt, f_rvalid;
   logic [7:0] rdata, mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       mem_en, mem_we;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(SM)) dut (
      .clk(clk), .rstn(rstn),
      .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   // reference model state: port ids 0=none 1=V 2=D 3=F
   logic [7:0] ref_mem [256];
   int         starve;
   int         exp_port;
   logic [7:0] exp_data;
   logic [7:0] last_rdata;
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      starve     = 0;
      exp_port   = 0;
      last_rdata = 8'h00;
   endtask

   // Called just after a falling edge with inputs set; checks this cycle, then advances one clock.
   task automatic cycle(output int win);
      logic [7:0] ea, ew;
      #1;
      check("v_rvalid", v_rvalid, exp_port == 1);
      check("d_rvalid", d_rvalid, exp_port == 2);
      check("f_rvalid", f_rvalid, exp_port == 3);
      if (exp_port != 0) last_rdata = exp_data;
      check("rdata", rdata, last_rdata);

      win = 0;
      if (v_req) win = 1;
      else if (f_req && starve == SM && !d_lock) win = 3;
      else if (d_req) win = 2;
      else if (f_req) win = 3;

      ea = (win == 1) ? v_addr : (win == 2) ? d_addr : (win == 3) ? f_addr : 8'h00;
      ew = (win == 2) ? d_wdata : 8'h00;
      check("v_gnt", v_gnt, win == 1);
      check("d_gnt", d_gnt, win == 2);
      check("f_gnt", f_gnt, win == 3);
      check("mem_en", mem_en, win != 0);
      check("mem_we", mem_we, win == 2 && d_we);
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ew);

      exp_port = 0;
      if (win == 2 && d_we) ref_mem[d_addr] = d_wdata;
      else if (win != 0) begin
         exp_port = win;
         exp_data = ref_mem[ea];
      end
      starve = (f_req && win != 3) ? ((starve < SM) ? starve + 1 : SM) : 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_reqs();
      v_req = 1'b0; d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0; f_req = 1'b0;
   endtask

   int win, pos, cnt;
   int order [3];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h00] = 8'h10;
      mem[8'h10] = 8'hC0; mem[8'h11] = 8'h20; mem[8'h12] = 8'hB4; mem[8'h13] = 8'h21;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      model_reset();

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_v_rvalid", v_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_f_rvalid", f_rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      rstn = 1'b1;
      @(negedge clk);

      // reset asserted while an F read is granted
      f_req = 1'b1; f_addr = 8'h10;
      #1 check("t1_f_gnt_before", f_gnt, 1);
      rstn = 1'b0;
      #1;
      check("t1_f_gnt_in_rst", f_gnt, 0);
      check("t1_mem_en_in_rst", mem_en, 0);
      f_req = 1'b0;
      @(posedge clk);
      #1;
      check("t1_f_rvalid", f_rvalid, 0);
      check("t1_rdata", rdata, 0);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      cycle(win);
      check("t1_idle", win, 0);

      // F-only sequential fetch
      for (int i = 0; i < 4; i++) begin
         f_req = 1'b1; f_addr = 8'h10 + 8'(i);
         cycle(win);
         check("t2_f_won", win, 3);
      end
      clear_reqs();
      cycle(win);

      // D write alongside F read, then read back the written byte
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'hFF; d_wdata = 8'h13;
      f_req = 1'b1; f_addr = 8'h20;
      cycle(win);
      check("t3_first", win, 2);
      d_req = 1'b0; d_we = 1'b0;
      cycle(win);
      check("t3_second", win, 3);
      f_req = 1'b0;
      d_req = 1'b1; d_addr = 8'hFF;
      cycle(win);
      d_req = 1'b0;
      cycle(win);
      check("t3_readback", last_rdata, 8'h13);

      // starvation override
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h11; f_req = 1'b1; f_addr = 8'h12;
      pos = 0;
      for (int i = 1; i <= SM + 2; i++) begin
         cycle(win);
         if (win == 3 && pos == 0) pos = i;
      end
      check("t4_f_slot", pos, SM + 1);
      check("t4_d_resumes", win, 2);

      // lock holds F off until released
      d_lock = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(win);
         if (win == 3) cnt++;
      end
      check("t5_f_locked_out", cnt, 0);
      d_lock = 1'b0;
      cycle(win);
      check("t5_release", win, 3);
      clear_reqs();
      cycle(win);

      // simultaneous V + D + F
      v_req = 1'b1; v_addr = 8'h00;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h13;
      f_req = 1'b1; f_addr = 8'h10;
      for (int i = 0; i < 3; i++) begin
         cycle(win);
         order[i] = win;
         if (win == 1) v_req = 1'b0;
         if (win == 2) d_req = 1'b0;
         if (win == 3) f_req = 1'b0;
         if (i == 0) check("t6_vec_data", exp_data, 8'h10);
      end
      check("t6_order0", order[0], 1);
      check("t6_order1", order[1], 2);
      check("t6_order2", order[2], 3);
      cycle(win);

      // randomized traffic obeying the hold-until-grant rule
      for (int n = 0; n < 1500; n++) begin
         if (!v_req && $urandom_range(0, 9) == 0) begin
            v_req = 1'b1; v_addr = 8'($urandom_range(0, 31));
         end
         if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom);
            d_lock  = ($urandom_range(0, 3) == 0);
            d_addr  = 8'($urandom_range(0, 31));
            d_wdata = 8'($urandom);
         end
         if (!f_req && $urandom_range(0, 9) < 7) begin
            f_req = 1'b1; f_addr = 8'($urandom_range(0, 31));
         end
         cycle(win);
         if (win == 1) v_req = 1'b0;
         if (win == 2) begin d_req = 1'b0; d_lock = 1'b0; end
         if (win == 3) f_req = 1'b0;
      end
      clear_reqs();
      cycle(win);
      cycle(win);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
